// File: rtl/sl_wb_slave_mem.sv
// Wishbone pipelined-mode slave backed by a word-addressed RAM, with programmable wait states.
// Defining SL_WB_SLAVE_MEM_RTY_EN adds a busy input that turns accepted requests into retries.
`ifndef WB_DATA_WIDTH
`define WB_DATA_WIDTH 32
`endif
`ifndef WB_ADDR_WIDTH
`define WB_ADDR_WIDTH 32
`endif
`ifndef WB_BE_WIDTH
`define WB_BE_WIDTH 4
`endif

module sl_wb_slave_mem #(
    parameter int unsigned DATA_W      = `WB_DATA_WIDTH,
    parameter int unsigned ADDR_W      = `WB_ADDR_WIDTH,
    parameter int unsigned BE_W        = `WB_BE_WIDTH,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cyc,
    input  logic              stb,
    input  logic              we,
    input  logic [ADDR_W-1:0] adr,
    input  logic [BE_W-1:0]   sel,
    input  logic [DATA_W-1:0] dat_o,
    input  logic              lock,
    input  logic              tga,
    input  logic              tgc,
`ifdef SL_WB_SLAVE_MEM_RTY_EN
    input  logic              busy,
`endif
    output logic [DATA_W-1:0] dat_i,
    output logic              ack,
    output logic              err,
    output logic              rty,
    output logic              stall
);

    localparam int unsigned OFF_W = $clog2(BE_W);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]        state;
    logic [1:0]        next_state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_d;
    logic              accept;
    logic              load;
    logic              commit;
    logic              busy_in;
    logic              we_q;
    logic              err_q;
    logic              rty_q;
    logic [BE_W-1:0]   sel_q;
    logic [DATA_W-1:0] dat_q;
    logic [IDX_W-1:0]  idx_q;
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] word_off;
    logic              in_err;
    logic [IDX_W-1:0]  in_idx;
    logic              src_err;
    logic              src_rty;
    logic              src_we;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] fwd_word;
    logic              ack_d;
    logic              err_d;
    logic              rty_d;
    logic [DATA_W-1:0] dat_d;
    logic [DATA_W-1:0] mem [DEPTH];

    logic unused_sigs;
    assign unused_sigs = &{1'b0, lock, tga, tgc};

`ifdef SL_WB_SLAVE_MEM_RTY_EN
    assign busy_in = busy;
`else
    assign busy_in = 1'b0;
`endif

    // Address decode of the incoming request
    assign offset   = adr - ADDR_W'(BASE_ADDR);
    assign word_off = offset >> OFF_W;
    assign in_err   = (adr < ADDR_W'(BASE_ADDR))
                   || (64'(word_off) >= 64'(DEPTH))
                   || (adr[OFF_W-1:0] != '0);
    assign in_idx   = IDX_W'(word_off);

    assign stall  = (state == ST_WAIT);
    assign accept = cyc && stb && !stall;
    assign commit = ack && we_q;

    always_comb begin
        next_state = state;
        cnt_d      = cnt;
        load       = 1'b0;
        case (state)
            ST_IDLE, ST_RESP: begin
                if (accept) begin
                    load       = 1'b1;
                    next_state = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt - CNT_W'(1);
                if (!cyc) begin
                    next_state = ST_IDLE;
                end else if (cnt == CNT_W'(1)) begin
                    next_state = ST_RESP;
                end
            end
            default: next_state = ST_IDLE;
        endcase
        if (load) begin
            cnt_d = CNT_W'(WAIT_CYCLES);
        end

        // Response attributes come from the new request or the one held through WAIT
        src_err = load ? in_err  : err_q;
        src_rty = load ? busy_in : rty_q;
        src_we  = load ? we      : we_q;
        rd_idx  = load ? in_idx  : idx_q;

        // A write committing on this edge must be visible to a read launched on the same edge
        fwd_word = mem[rd_idx];
        if (commit && (idx_q == rd_idx)) begin
            for (int i = 0; i < BE_W; i++) begin
                if (sel_q[i]) begin
                    fwd_word[8*i +: 8] = dat_q[8*i +: 8];
                end
            end
        end

        ack_d = (next_state == ST_RESP) && !src_err && !src_rty;
        err_d = (next_state == ST_RESP) && src_err;
        rty_d = (next_state == ST_RESP) && !src_err && src_rty;
        dat_d = (ack_d && !src_we) ? fwd_word : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            we_q  <= 1'b0;
            err_q <= 1'b0;
            rty_q <= 1'b0;
            sel_q <= '0;
            dat_q <= '0;
            idx_q <= '0;
            ack   <= 1'b0;
            err   <= 1'b0;
            rty   <= 1'b0;
            dat_i <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_d;
            ack   <= ack_d;
            err   <= err_d;
            rty   <= rty_d;
            dat_i <= dat_d;
            if (load) begin
                we_q  <= we;
                err_q <= in_err;
                rty_q <= busy_in;
                sel_q <= sel;
                dat_q <= dat_o;
                idx_q <= in_idx;
            end
        end
    end

    // Storage is not reset; byte-lane write lands at the end of the ack cycle
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < BE_W; i++) begin
                if (sel_q[i]) begin
                    mem[idx_q][8*i +: 8] <= dat_q[8*i +: 8];
                end
            end
        end
    end

`ifndef SYNTHESIS
    a_no_term_in_idle: assert property (@(posedge clk) disable iff (!rst)
        (state == ST_IDLE) |-> !(ack || err || rty));
    a_stb_without_cyc: assert property (@(posedge clk) disable iff (!rst)
        (state == ST_IDLE && stb && !cyc) |=> (state == ST_IDLE));
    a_one_term: assert property (@(posedge clk) disable iff (!rst)
        $onehot0({ack, err, rty}));
`endif

endmodule
